// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns a single pipeline load or store into one bus
// access. It stalls the pipeline while the access is outstanding, aligns and
// extends load data, and flags misaligned, illegal and timed-out accesses.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        fault,
  output logic [1:0]  faultCause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;
  localparam logic [7:0] TIMEOUT_LIM    = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [31:0] addr_r;
  logic [2:0]  f3_r;
  logic [31:0] wd_r;
  logic        we_r;
  logic [7:0]  wait_cnt;
  logic [1:0]  err_cause;

  logic        request;
  logic        illegal;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] rd_lane;
  logic [31:0] load_ext;
  logic [3:0]  be_sel;

  // Decode of the incoming instruction; only meaningful while idle.
  assign request     = memRead | memWrite;
  assign illegal     = (memRead & memWrite) ||
                       (funct3 inside {3'b011, 3'b110, 3'b111});
  assign misaligned  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign timeout_hit = (wait_cnt + 8'd1) == TIMEOUT_LIM;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision, pipeline stall and the fault cause to record.
  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    err_cause = 2'b00;
    unique case (state)
      S_IDLE: begin
        stall = request;
        if (request) begin
          if (illegal) begin
            state_nxt = S_ERR;
            err_cause = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            state_nxt = S_ERR;
            err_cause = CAUSE_MISALIGN;
          end else begin
            state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (memAck) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
          err_cause = CAUSE_TIMEOUT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the instruction's operands when it is first presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
      f3_r   <= '0;
      wd_r   <= '0;
      we_r   <= 1'b0;
    end else if (state == S_IDLE && request) begin
      addr_r <= addr;
      f3_r   <= funct3;
      wd_r   <= writeData;
      we_r   <= memWrite;
    end
  end

  // Wait counter: restarts with each access, counts cycles without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              wait_cnt <= '0;
    else if (state == S_IDLE)             wait_cnt <= '0;
    else if (state == S_ACCESS && !memAck) wait_cnt <= wait_cnt + 8'd1;
  end

  // Fault cause is sticky until the next fault overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    faultCause <= 2'b00;
    else if (state_nxt == S_ERR) faultCause <= err_cause;
  end

  // Lane-select the returned word and extend it to 32 bits.
  always_comb begin
    rd_lane  = memRdata >> {addr_r[1:0], 3'b000};
    load_ext = memRdata;
    unique case (f3_r)
      3'b000:  load_ext = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'b001:  load_ext = {{16{rd_lane[15]}}, rd_lane[15:0]};
      3'b100:  load_ext = {24'd0, rd_lane[7:0]};
      3'b101:  load_ext = {16'd0, rd_lane[15:0]};
      default: load_ext = memRdata;
    endcase
  end

  // Load result register; holds until the next load completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      loadData <= '0;
    else if (state == S_ACCESS && memAck && !we_r) loadData <= load_ext;
  end

  // Byte enables and replicated store data from the captured operands.
  always_comb begin
    be_sel   = 4'b1111;
    memWdata = wd_r;
    unique case (f3_r[1:0])
      2'b00: begin
        be_sel   = 4'b0001 << addr_r[1:0];
        memWdata = {4{wd_r[7:0]}};
      end
      2'b01: begin
        be_sel   = addr_r[1] ? 4'b1100 : 4'b0011;
        memWdata = {2{wd_r[15:0]}};
      end
      default: begin
        be_sel   = 4'b1111;
        memWdata = wd_r;
      end
    endcase
  end

  assign memReq    = (state == S_ACCESS);
  assign memWe     = memReq & we_r;
  assign memBe     = memReq ? be_sel : 4'b0000;
  assign memAddr   = {addr_r[31:2], 2'b00};
  assign loadValid = (state == S_DONE) & ~we_r;
  assign fault     = (state == S_ERR);

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: a transaction-level timeline model
// sets per-cycle expectations, one compare process checks them on every
// falling edge, and literal checks pin the key scenarios.
module tb_lsu_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data, mem_rdata;
  logic        mem_req, mem_we, stall, load_valid, fault;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  // model state (what the DUT should have captured / produced)
  logic [31:0] m_addr, m_wd, m_load;
  logic [2:0]  m_f3;
  logic        m_we;
  logic [1:0]  m_cause;
  // per-cycle expectations
  logic        e_req, e_stall, e_lv, e_fault, e_we;
  logic [3:0]  e_be;
  bit          chk_en = 1'b0;

  // observations from the last run_op, for literal checks
  int          r_req_cycles;
  logic [31:0] r_first_addr, r_first_wdata, r_done_ld;
  logic [3:0]  r_first_be;
  logic        r_first_we, r_done_lv, r_done_fault;
  logic [1:0]  r_done_cause;

  always #5 clk = ~clk;

  lsu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memRead(mem_read), .memWrite(mem_write), .funct3(funct3),
    .addr(addr), .writeData(write_data),
    .memReq(mem_req), .memWe(mem_we), .memAddr(mem_addr), .memBe(mem_be),
    .memWdata(mem_wdata), .memRdata(mem_rdata), .memAck(mem_ack),
    .stall(stall), .loadData(load_data), .loadValid(load_valid),
    .fault(fault), .faultCause(fault_cause)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a[1:0] +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [1:0] f_cause(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [31:0] a);
    if ((rd && wr) || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 2'b11;
    if (f3[1:0] == 2'b01 && a[0]) return 2'b01;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 2'b01;
    return 2'b00;
  endfunction

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("memReq", 32'(mem_req), 32'(e_req));
      check("stall", 32'(stall), 32'(e_stall));
      check("loadValid", 32'(load_valid), 32'(e_lv));
      check("fault", 32'(fault), 32'(e_fault));
      check("memBe", 32'(mem_be), 32'(e_be));
      check("faultCause", 32'(fault_cause), 32'(m_cause));
      check("loadData", load_data, m_load);
      if (e_req) begin
        check("memAddr", mem_addr, {m_addr[31:2], 2'b00});
        check("memWe", 32'(mem_we), 32'(e_we));
        check("memWdata", mem_wdata, f_wdata(m_f3, m_wd));
      end
    end
  end

  task automatic set_idle_exp();
    e_req = 0; e_stall = 0; e_lv = 0; e_fault = 0; e_be = 4'b0000; e_we = 0;
  endtask

  // One instruction: request cycle, access cycles (ack in cycle ack_at,
  // 0 = never), completion cycle, one idle cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_at, input bit late_ack);
    logic [1:0] cause;
    int  cyc;
    bit  acked, timed_out;
    cause = f_cause(rd, wr, f3, a);
    r_req_cycles = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = wd;
    mem_rdata = rdata; mem_ack = 0;
    set_idle_exp();
    e_stall = rd | wr;
    @(posedge clk); #1;
    m_addr = a; m_f3 = f3; m_wd = wd; m_we = wr;
    if (cause != 2'b00) begin
      set_idle_exp();
      e_fault = 1;
      m_cause = cause;
    end else begin
      cyc = 0; acked = 0; timed_out = 0;
      while (!acked && !timed_out) begin
        cyc++;
        e_req = 1; e_stall = 1; e_be = f_be(f3, a); e_we = wr;
        mem_ack = (cyc == ack_at);
        @(negedge clk);
        if (mem_req) r_req_cycles++;
        if (cyc == 1) begin
          r_first_addr = mem_addr; r_first_be = mem_be;
          r_first_wdata = mem_wdata; r_first_we = mem_we;
        end
        @(posedge clk); #1;
        mem_ack = 0;
        if (cyc == ack_at) acked = 1;
        else if (cyc == TO) timed_out = 1;
      end
      set_idle_exp();
      if (acked) begin
        e_lv = !wr;
        if (!wr) m_load = f_load(f3, a, rdata);
      end else begin
        e_fault = 1;
        m_cause = 2'b10;
      end
    end
    mem_ack = late_ack;
    @(negedge clk);
    r_done_lv = load_valid; r_done_ld = load_data;
    r_done_fault = fault; r_done_cause = fault_cause;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    set_idle_exp();
    @(negedge clk);
    mem_ack = 0;
  endtask

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; mem_ack = 0; funct3 = 0;
    addr = 0; write_data = 0; mem_rdata = 0;
    m_addr = 0; m_wd = 0; m_load = 0; m_f3 = 0; m_we = 0; m_cause = 0;
    set_idle_exp();
    #2;
    check("rst memReq", 32'(mem_req), 0);
    check("rst memWe", 32'(mem_we), 0);
    check("rst memBe", 32'(mem_be), 0);
    check("rst memAddr", mem_addr, 0);
    check("rst memWdata", mem_wdata, 0);
    check("rst loadData", load_data, 0);
    check("rst loadValid", 32'(load_valid), 0);
    check("rst fault", 32'(fault), 0);
    check("rst faultCause", 32'(fault_cause), 0);
    check("rst stall", 32'(stall), 0);
    #10 rst = 0;
    chk_en = 1;

    // LB 0x1003, ack in first access cycle
    run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 0);
    check("LB memAddr", r_first_addr, 32'h0000_1000);
    check("LB memBe", 32'(r_first_be), 32'(4'b1000));
    check("LB loadData", r_done_ld, 32'hFFFF_FF80);
    check("LB loadValid N+2", 32'(r_done_lv), 1);

    // SH 0x2002, ack on 4th access cycle (same cycle as the timeout limit)
    run_op(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 4, 0);
    check("SH memWe", 32'(r_first_we), 1);
    check("SH memBe", 32'(r_first_be), 32'(4'b1100));
    check("SH memWdata", r_first_wdata, 32'hABCD_ABCD);
    check("SH no loadValid", 32'(r_done_lv), 0);
    check("SH no fault", 32'(r_done_fault), 0);

    // LW misaligned
    run_op(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1, 0);
    check("LW mis memReq cycles", r_req_cycles, 0);
    check("LW mis fault", 32'(r_done_fault), 1);
    check("LW mis cause", 32'(r_done_cause), 32'(2'b01));

    // LHU without ack -> timeout, then late ack ignored
    run_op(1, 0, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 0, 1);
    check("LHU to memReq cycles", r_req_cycles, TO);
    check("LHU to fault", 32'(r_done_fault), 1);
    check("LHU to cause", 32'(r_done_cause), 32'(2'b10));
    check("LHU to loadData held", r_done_ld, 32'hFFFF_FF80);

    // illegal: read and write together, then bad funct3
    run_op(1, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 1, 0);
    check("rw illegal cause", 32'(r_done_cause), 32'(2'b11));
    run_op(1, 0, 3'b011, 32'h0000_0108, 32'h0, 32'h0, 1, 0);
    check("f3 illegal cause", 32'(r_done_cause), 32'(2'b11));

    // assorted legal accesses
    run_op(1, 0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 2, 0);
    check("LH loadData", r_done_ld, 32'hFFFF_8001);
    run_op(0, 1, 3'b000, 32'h0000_0007, 32'h0000_00AB, 32'h0, 1, 0);
    check("SB memWdata", r_first_wdata, 32'hABAB_ABAB);
    run_op(0, 1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 3, 0);
    run_op(1, 0, 3'b001, 32'h0000_0005, 32'h0, 32'h0, 1, 0);
    check("LH mis cause", 32'(r_done_cause), 32'(2'b01));
    run_op(1, 0, 3'b000, 32'h0000_0021, 32'h0, 32'h0000_7F00, 1, 0);
    check("LB pos loadData", r_done_ld, 32'h0000_007F);

    // reset in the middle of an access
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_6000;
    mem_ack = 0; set_idle_exp(); e_stall = 1;
    @(posedge clk); #1;
    m_addr = addr; m_f3 = funct3; m_wd = write_data; m_we = 0;
    e_req = 1; e_stall = 1; e_be = 4'b1111; e_we = 0;
    @(negedge clk); #2;
    chk_en = 0;
    rst = 1;
    #1;
    check("mid rst memReq", 32'(mem_req), 0);
    check("mid rst memBe", 32'(mem_be), 0);
    check("mid rst memAddr", mem_addr, 0);
    check("mid rst memWdata", mem_wdata, 0);
    check("mid rst loadData", load_data, 0);
    check("mid rst faultCause", 32'(fault_cause), 0);
    check("mid rst fault", 32'(fault), 0);
    @(posedge clk); #1;
    rst = 0; mem_read = 0;
    m_addr = 0; m_wd = 0; m_f3 = 0; m_we = 0; m_load = 0; m_cause = 0;
    set_idle_exp();
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);

    // LBU after reset
    run_op(1, 0, 3'b100, 32'h0000_5001, 32'h0, 32'h0000_9A00, 1, 0);
    check("LBU loadData", r_done_ld, 32'h0000_009A);
    run_op(1, 0, 3'b010, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1, 0);
    check("LW loadData", r_done_ld, 32'hDEAD_BEEF);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
